adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 96 +++++++++
 tb/tb_adder_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Two-requester round-robin arbiter in front of a single registered 8-bit adder.
// Define ADDER_ARB_SAT_EN to clamp the sum to 8'hFF on carry-out (co still reports the carry).
module adder_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] a0,
   input  logic [7:0] b0,
   input  logic [7:0] a1,
   input  logic [7:0] b1,
   input  logic       cin0,
   input  logic       cin1,
   output logic [1:0] gnt,
   output logic       ack0,
   output logic       ack1,
   output logic [7:0] sum,
   output logic       co,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t     state;
   state_t     state_nxt;
   logic       last_gnt;
   logic       pick1;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       op_c;
   logic [8:0] raw;

   // On a tie, requester 1 wins only if requester 0 was granted last.
   always_comb begin
      pick1 = req1 & (~req0 | ~last_gnt);
      raw   = {1'b0, op_a} + {1'b0, op_b} + {8'b0, op_c};
      busy  = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req0 | req1) state_nxt = EXEC;
         EXEC:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt      <= 2'b00;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         sum      <= 8'h00;
         co       <= 1'b0;
         op_a     <= 8'h00;
         op_b     <= 8'h00;
         op_c     <= 1'b0;
         last_gnt <= 1'b1;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  gnt      <= pick1 ? 2'b10 : 2'b01;
                  last_gnt <= pick1;
                  op_a     <= pick1 ? a1 : a0;
                  op_b     <= pick1 ? b1 : b0;
                  op_c     <= pick1 ? cin1 : cin0;
               end
            end
            EXEC: begin
`ifdef ADDER_ARB_SAT_EN
               sum <= raw[8] ? 8'hFF : raw[7:0];
`else
               sum <= raw[7:0];
`endif
               co   <= raw[8];
               // The ack lands in DONE, the cycle the fresh result is visible.
               ack0 <= gnt[0];
               ack1 <= gnt[1];
            end
            DONE: gnt <= 2'b00;
            default: gnt <= 2'b00;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: drivers queue expected results, a negedge monitor checks
// grants, ack timing, results and idle hold against a transaction-level arbitration model.
module tb_adder_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0;
   logic       req1 = 1'b0;
   logic [7:0] a0 = 8'h00;
   logic [7:0] b0 = 8'h00;
   logic [7:0] a1 = 8'h00;
   logic [7:0] b1 = 8'h00;
   logic       cin0 = 1'b0;
   logic       cin1 = 1'b0;
   logic [1:0] gnt;
   logic       ack0;
   logic       ack1;
   logic [7:0] sum;
   logic       co;
   logic       busy;

   int tests = 0;
   int fails = 0;

   logic [8:0] expq0[$];
   logic [8:0] expq1[$];
   logic       model_last;
   logic [8:0] model_res;
   logic       prev_busy;
   logic [1:0] prev_req;
   logic [1:0] exp_g;
   logic       due;
   logic [8:0] popped;

   adder_arbiter dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req0 (req0),
      .req1 (req1),
      .a0   (a0),
      .b0   (b0),
      .a1   (a1),
      .b1   (b1),
      .cin0 (cin0),
      .cin1 (cin1),
      .gnt  (gnt),
      .ack0 (ack0),
      .ack1 (ack1),
      .sum  (sum),
      .co   (co),
      .busy (busy)
   );

   always #5 clk = ~clk;

   // Reference result {co,sum} from plain integer arithmetic.
   function automatic logic [8:0] refAdd(input logic [7:0] a, input logic [7:0] b, input logic c);
      int s;
      logic [8:0] r;
      s = int'(a) + int'(b) + int'(c);
      r[8]   = (s > 255);
      r[7:0] = s[7:0];
`ifdef ADDER_ARB_SAT_EN
      if (s > 255) r[7:0] = 8'hFF;
`endif
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Raise one request after a delay, hold it until its ack, then drop it.
   task automatic applyStimulus(input int r, input logic [7:0] a, input logic [7:0] b,
                                input logic c, input int delay);
      bit got = 1'b0;
      repeat (delay) @(posedge clk);
      #1;
      if (r == 0) begin
         a0 = a; b0 = b; cin0 = c;
         expq0.push_back(refAdd(a, b, c));
         req0 = 1'b1;
      end else begin
         a1 = a; b1 = b; cin1 = c;
         expq1.push_back(refAdd(a, b, c));
         req1 = 1'b1;
      end
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = (r == 0) ? ack0 : ack1;
      end
      if (!got) checkOutput("ack timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (r == 0) req0 = 1'b0;
      else        req1 = 1'b0;
   endtask

   // Monitor: grant on busy rise, ack exactly one cycle later, results hold while idle.
   always @(negedge clk) begin
      if (!rst_n) begin
         model_last = 1'b1;
         model_res  = 9'h000;
         prev_busy  = 1'b0;
         due        = 1'b0;
         exp_g      = 2'b00;
      end else if (busy && !prev_busy) begin
         if (prev_req == 2'b11) exp_g = model_last ? 2'b01 : 2'b10;
         else                   exp_g = prev_req;
         checkOutput("grant", 32'(gnt), 32'(exp_g));
         model_last = exp_g[1];
         due = 1'b1;
      end else if (due) begin
         checkOutput("ack", 32'({ack1, ack0}), 32'(exp_g));
         checkOutput("gnt hold", 32'(gnt), 32'(exp_g));
         checkOutput("busy done", 32'(busy), 32'd1);
         if (exp_g[0] && expq0.size() > 0) begin
            popped = expq0.pop_front();
            checkOutput("result0", 32'({co, sum}), 32'(popped));
            model_res = popped;
         end else if (exp_g[1] && expq1.size() > 0) begin
            popped = expq1.pop_front();
            checkOutput("result1", 32'({co, sum}), 32'(popped));
            model_res = popped;
         end else begin
            checkOutput("scoreboard empty", 32'd0, 32'd1);
         end
         due = 1'b0;
      end else begin
         checkOutput("no ack", 32'({ack1, ack0}), 32'd0);
         if (!busy) begin
            checkOutput("idle gnt", 32'(gnt), 32'd0);
            checkOutput("sum hold", 32'({co, sum}), 32'(model_res));
         end
      end
      prev_busy = busy;
      prev_req  = {req1, req0};
   end

   task automatic checkResetState(input string tag);
      checkOutput({tag, " gnt"}, 32'(gnt), 32'd0);
      checkOutput({tag, " ack"}, 32'({ack1, ack0}), 32'd0);
      checkOutput({tag, " busy"}, 32'(busy), 32'd0);
      checkOutput({tag, " sum"}, 32'(sum), 32'd0);
      checkOutput({tag, " co"}, 32'(co), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [1:0] mask;
      int d0, d1;
      bit seen;

      repeat (2) @(negedge clk);
      checkResetState("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Tie right after reset: requester 0 first, then requester 1.
      fork
         applyStimulus(0, 8'h12, 8'h34, 1'b0, 0);
         applyStimulus(1, 8'h0F, 8'h01, 1'b1, 0);
      join
      applyStimulus(0, 8'h12, 8'h34, 1'b0, 0);
      fork
         applyStimulus(0, 8'h21, 8'h43, 1'b1, 0);
         applyStimulus(1, 8'h80, 8'h80, 1'b0, 0);
      join
      applyStimulus(0, 8'hFF, 8'h01, 1'b1, 0);

      // Operand change after the grant must not leak into the result.
      fork
         applyStimulus(0, 8'h10, 8'h01, 1'b0, 0);
         begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
               @(negedge clk);
               seen = gnt[0];
            end
            a0 = 8'h99;
         end
      join

      for (int n = 0; n < 40; n++) begin
         mask = 2'($urandom_range(1, 3));
         d0 = $urandom_range(0, 3);
         d1 = $urandom_range(0, 3);
         fork
            if (mask[0]) applyStimulus(0, 8'($urandom), 8'($urandom), 1'($urandom), d0);
            if (mask[1]) applyStimulus(1, 8'($urandom), 8'($urandom), 1'($urandom), d1);
         join
      end

      // Reset in EXEC aborts the add; no ack must follow.
      @(posedge clk);
      #1;
      a0 = 8'h55; b0 = 8'h22; cin0 = 1'b1; req0 = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = busy;
      end
      if (!seen) checkOutput("busy timeout", 32'd0, 32'd1);
      #1 rst_n = 1'b0;
      #1 checkResetState("mid reset");
      req0 = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(1, 8'h05, 8'h06, 1'b0, 0);
      fork
         applyStimulus(0, 8'hF0, 8'h20, 1'b0, 0);
         applyStimulus(1, 8'h01, 8'h01, 1'b1, 0);
      join

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
